// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic multiplier: FSM encoding,
// LFSR geometry (31-bit Fibonacci, taps 30/27) and default seeds.
package sc_pkg;

   localparam int LFSR_W = 31;
   localparam int TAP_HI = 30;
   localparam int TAP_LO = 27;

   localparam logic [LFSR_W-1:0] SEED_A_DEF = 31'd1;
   localparam logic [LFSR_W-1:0] SEED_B_DEF = 31'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sc_state_e;

   // An all-zero LFSR never leaves zero, so a zero seed is forced to 1.
   function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
      return (s == '0) ? LFSR_W'(1) : s;
   endfunction

endpackage

// File: rtl/sc_lfsr31.sv
// 31-bit Fibonacci LFSR (bit30 ^ bit27 into bit0); load beats advance.
// Only the low OUT_W bits leave the block since that is all the comparators use.
module sc_lfsr31
   import sc_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RST_SEED = SEED_A_DEF,
   parameter int                OUT_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   output logic [OUT_W-1:0]  rnd
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = seed;
      end else if (adv) begin
         lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= RST_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/stoch_mult_win.sv
// Windowed stochastic multiplier: AND (unipolar) or XNOR (bipolar) of two LFSR bitstreams,
// counting 1s over 2^WIN_LOG2 cycles. Define SC_LFSR_RESEED_EN to reseed both LFSRs on each start.
module stoch_mult_win
   import sc_pkg::*;
#(
   parameter int                N        = 4,
   parameter int                WIN_LOG2 = 3,
   parameter logic [LFSR_W-1:0] SEED_A   = SEED_A_DEF,
   parameter logic [LFSR_W-1:0] SEED_B   = SEED_B_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic              mode,
   input  logic [N-1:0]      prob_a,
   input  logic [N-1:0]      prob_b,
   output logic              busy,
   output logic              sn_out,
   output logic [WIN_LOG2:0] result,
   output logic              result_valid,
   output logic [1:0]        dbg_state
);

   localparam int CW = WIN_LOG2 + 1;
   localparam logic [LFSR_W-1:0] SEED_A_FIX = fix_seed(SEED_A);
   localparam logic [LFSR_W-1:0] SEED_B_FIX = fix_seed(SEED_B);

   sc_state_e         state_q, state_d;
   logic [N-1:0]      prob_a_q, prob_a_d;
   logic [N-1:0]      prob_b_q, prob_b_d;
   logic              mode_q, mode_d;
   logic [WIN_LOG2-1:0] win_q, win_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sn_q, sn_d;
   logic [CW-1:0]     res_q, res_d;
   logic              rv_q, rv_d;

   logic [N-1:0] rnd_a, rnd_b;
   logic         bit_a, bit_b, sn;
   logic         accept, adv, load;

   assign accept = ena && (state_q == ST_IDLE) && start;
   assign adv    = ena && (state_q == ST_RUN);
`ifdef SC_LFSR_RESEED_EN
   assign load   = accept;
`else
   assign load   = 1'b0;
`endif

   sc_lfsr31 #(.RST_SEED(SEED_A_FIX), .OUT_W(N)) u_lfsr_a (
      .clk(clk), .rst_n(rst_n), .adv(adv), .load(load), .seed(SEED_A_FIX), .rnd(rnd_a)
   );

   sc_lfsr31 #(.RST_SEED(SEED_B_FIX), .OUT_W(N)) u_lfsr_b (
      .clk(clk), .rst_n(rst_n), .adv(adv), .load(load), .seed(SEED_B_FIX), .rnd(rnd_b)
   );

   always_comb begin
      bit_a = (rnd_a < prob_a_q);
      bit_b = (rnd_b < prob_b_q);
      sn    = mode_q ? ~(bit_a ^ bit_b) : (bit_a & bit_b);

      state_d  = state_q;
      prob_a_d = prob_a_q;
      prob_b_d = prob_b_q;
      mode_d   = mode_q;
      win_d    = win_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      sn_d     = 1'b0;
      rv_d     = 1'b0;

      if (!ena) begin
         sn_d = sn_q;
         rv_d = rv_q;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  prob_a_d = prob_a;
                  prob_b_d = prob_b;
                  mode_d   = mode;
                  win_d    = '0;
                  cnt_d    = '0;
                  state_d  = ST_RUN;
               end
            end
            ST_RUN: begin
               sn_d  = sn;
               cnt_d = cnt_q + CW'(sn);
               win_d = win_q + WIN_LOG2'(1);
               // Last window slot: the counter wraps back to zero on this edge.
               if (win_q == '1) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               res_d   = cnt_q;
               rv_d    = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         prob_a_q <= '0;
         prob_b_q <= '0;
         mode_q   <= 1'b0;
         win_q    <= '0;
         cnt_q    <= '0;
         sn_q     <= 1'b0;
         res_q    <= '0;
         rv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         prob_a_q <= prob_a_d;
         prob_b_q <= prob_b_d;
         mode_q   <= mode_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         sn_q     <= sn_d;
         res_q    <= res_d;
         rv_q     <= rv_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign sn_out       = sn_q;
   assign result       = res_q;
   assign result_valid = rv_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_stoch_mult_win.sv
// Scoreboard bench for stoch_mult_win: a reference LFSR/bitstream model pushes the
// expected count per accepted start; each result_valid strobe pops and compares.
module tb_stoch_mult_win;
   import sc_pkg::*;

   localparam int N   = 4;
   localparam int W   = 3;
   localparam int WIN = 1 << W;
   localparam int CW  = W + 1;

   logic          clk;
   logic          rst_n;
   logic          ena;
   logic          start;
   logic          mode;
   logic [N-1:0]  prob_a;
   logic [N-1:0]  prob_b;
   logic          busy;
   logic          sn_out;
   logic [CW-1:0] result;
   logic          result_valid;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0]  exp_q[$];
   logic [30:0]    ma, mb;
   logic [WIN-1:0] exp_sn;

   stoch_mult_win #(.N(N), .WIN_LOG2(W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
      .prob_a(prob_a), .prob_b(prob_b), .busy(busy), .sn_out(sn_out),
      .result(result), .result_valid(result_valid), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed timeout required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [30:0] lfsr_step(input logic [30:0] s);
      return {s[29:0], s[30] ^ s[27]};
   endfunction

   task automatic model_reset();
      ma = 31'd1;
      mb = 31'd2;
   endtask

   // Reference window: compare, combine, count, advance.
   task automatic model_window(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
      logic ba, bb, s;
      logic [CW-1:0] cnt;
`ifdef SC_LFSR_RESEED_EN
      model_reset();
`endif
      cnt = '0;
      for (int i = 0; i < WIN; i++) begin
         ba = (ma[N-1:0] < a);
         bb = (mb[N-1:0] < b);
         s  = m ? ~(ba ^ bb) : (ba & bb);
         exp_sn[i] = s;
         cnt = cnt + CW'(s);
         ma = lfsr_step(ma);
         mb = lfsr_step(mb);
      end
      exp_q.push_back(cnt);
   endtask

   // driver: one accepted start, optional ena gap and start poke during RUN
   task automatic run_window(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                             input int gap_at, input int gap_len, input bit poke,
                             output logic [CW-1:0] res);
      int lat, busy_n, extra;
      bit got;
      logic [CW-1:0] e;
      @(negedge clk);
      prob_a = a;
      prob_b = b;
      mode   = m;
      start  = 1'b1;
      model_window(a, b, m);
      lat = 0;
      busy_n = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (busy) busy_n++;
         if (gap_len == 0 && lat >= 2 && lat <= WIN + 1)
            check_eq("sn_out", sn_out, exp_sn[lat-2]);
         if (result_valid) got = 1'b1;
         if (lat == 1) begin
            start  = 1'b0;
            prob_a = ~a;
            prob_b = ~b;
            mode   = ~m;
         end
         if (poke && lat == 3) start = 1'b1;
         if (poke && lat == 4) start = 1'b0;
         if (gap_len > 0 && lat == gap_at) ena = 1'b0;
         if (gap_len > 0 && lat == gap_at + gap_len) ena = 1'b1;
      end
      check_eq("valid_seen", got, 1);
      check_eq("latency", lat, WIN + 2 + gap_len);
      check_eq("busy_cycles", busy_n, WIN + 1 + gap_len);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check_eq("result", result, e);
      res = result;
      @(negedge clk);
      check_eq("valid_pulse_end", result_valid, 0);
      check_eq("sn_idle", sn_out, 0);
      check_eq("busy_idle", busy, 0);
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (result_valid) extra++;
      end
      check_eq("extra_valid", extra, 0);
      check_eq("result_hold", result, e);
   endtask

   task automatic run_reset_abort(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
      int extra;
      logic [CW-1:0] dropped;
      @(negedge clk);
      prob_a = a;
      prob_b = b;
      mode   = m;
      start  = 1'b1;
      model_window(a, b, m);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_sn", sn_out, 0);
      check_eq("abort_result", result, 0);
      check_eq("abort_valid", result_valid, 0);
      check_eq("abort_state", dbg_state, 32'(ST_IDLE));
      dropped = exp_q.pop_back();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (14) begin
         @(negedge clk);
         if (result_valid) extra++;
      end
      check_eq("abort_no_strobe", extra, 0);
      check_eq("abort_still_idle", busy, 0);
   endtask

   initial begin
      logic [CW-1:0] r, r1, r2;
      rst_n  = 1'b0;
      ena    = 1'b1;
      start  = 1'b0;
      mode   = 1'b0;
      prob_a = '0;
      prob_b = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_sn", sn_out, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_valid", result_valid, 0);
      check_eq("rst_state", dbg_state, 32'(ST_IDLE));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_window(4'd0, 4'd15, 1'b0, 0, 0, 1'b0, r);
      check_eq("zero_prob_a", r, 0);
      run_window(4'd0, 4'd0, 1'b1, 0, 0, 1'b0, r);
      check_eq("full_window", r, WIN);
      run_window(4'd9, 4'd0, 1'b0, 0, 0, 1'b0, r);
      check_eq("and_zero_b", r, 0);
      run_window(4'd9, 4'd0, 1'b1, 0, 0, 1'b0, r);
      run_window(4'd5, 4'd11, 1'b0, 0, 0, 1'b1, r);

      run_reset_abort(4'd7, 4'd12, 1'b0);
      run_window(4'd7, 4'd7, 1'b1, 0, 0, 1'b0, r);

      run_window(4'd10, 4'd13, 1'b0, 3, 5, 1'b0, r);

      run_window(4'd6, 4'd10, 1'b0, 0, 0, 1'b0, r1);
      run_window(4'd6, 4'd10, 1'b0, 0, 0, 1'b0, r2);
`ifdef SC_LFSR_RESEED_EN
      check_eq("reseed_repeat", r2, 32'(r1));
`endif

      for (int i = 0; i < 8; i++) begin
         run_window(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), r);
      end

      check_eq("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stoch_mult_win.md
STOCH_MULT_WIN -- requirements
Module: stoch_mult_win

Interface
REQ-001 SHALL have parameter N, default 4: probability operand width, range 2..16.
REQ-002 SHALL have parameter WIN_LOG2, default 3: accumulation window is 2^WIN_LOG2 bitstream cycles, range 1..12.
REQ-003 SHALL have parameter SEED_A, default 31'd1: initial state of LFSR A.
REQ-004 SHALL have parameter SEED_B, default 31'd2: initial state of LFSR B.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port ena, input, 1: clock enable; when low, all state holds.
REQ-008 SHALL have port start, input, 1: request one conversion window.
REQ-009 SHALL have port mode, input, 1: 0 = unipolar (AND), 1 = bipolar (XNOR).
REQ-010 SHALL have port prob_a, input, N: operand A probability.
REQ-011 SHALL have port prob_b, input, N: operand B probability.
REQ-012 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-013 SHALL have port sn_out, output, 1: product stochastic bit, registered.
REQ-014 SHALL have port result, output, WIN_LOG2+1: count of 1s in the last completed window.
REQ-015 SHALL have port result_valid, output, 1: one-cycle strobe when result updates.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE, and SHALL advance only when ena=1.
REQ-017 IDLE with start=1 SHALL latch prob_a, prob_b and mode, clear the window counter and count register, and enter RUN.
REQ-018 RUN SHALL last exactly 2^WIN_LOG2 cycles, then enter DONE.
REQ-019 DONE SHALL last one cycle: load result from the count register, pulse result_valid=1, return to IDLE.
REQ-020 Each RUN cycle SHALL form bit_a = (lfsrA[N-1:0] < latched prob_a) and bit_b = (lfsrB[N-1:0] < latched prob_b).
REQ-021 Each RUN cycle SHALL set sn = bit_a & bit_b when mode=0, and sn = ~(bit_a ^ bit_b) when mode=1.
REQ-022 sn_out SHALL be register sn, updated in RUN only, and SHALL be 0 otherwise.
REQ-023 The count register SHALL be WIN_LOG2+1 bits and SHALL increment on each RUN cycle with sn=1, so a full count of 2^WIN_LOG2 is representable without wrap or overflow flag.
REQ-024 Each LFSR SHALL be 31-bit Fibonacci, tap feedback bit30^bit27 shifted into bit0, and SHALL advance only in RUN.
REQ-025 A seed parameter equal to 0 SHALL be replaced by 31'd1 to prevent lock-up.
REQ-026 start outside IDLE SHALL be ignored, with no queuing.
REQ-027 Operand or mode changes during RUN SHALL have no effect on the current window.
REQ-028 result SHALL hold its value until the next DONE.
REQ-029 start latency SHALL be: accepted at edge k, result_valid high in the cycle after edge k+2^WIN_LOG2+1, with ena held high throughout.

Reset
REQ-030 rst_n low SHALL asynchronously set: FSM=IDLE, busy=0, sn_out=0, result=0, result_valid=0, count=0, window counter=0, LFSR A=SEED_A, LFSR B=SEED_B.
REQ-031 Reset mid-RUN SHALL abort the window with no result_valid strobe.

Configuration
REQ-032 With macro SC_LFSR_RESEED_EN defined, both LFSRs SHALL reload their seeds on each accepted start, so identical operands give identical results.
REQ-033 Without SC_LFSR_RESEED_EN, the LFSRs SHALL continue from their current state across windows.

Structure
REQ-034 Shared package sc_pkg SHALL hold the FSM state enum, the LFSR width constant (31), tap positions and default seeds.
REQ-035 A sub-module sc_lfsr31 SHALL be used, with ports clk, rst_n, adv, load and seed, instanced twice.

Verification
REQ-036 Default params, mode=0, prob_a=0, prob_b=15, start -> result=0, result_valid pulse exactly 10 cycles after the start edge.
REQ-037 Mode=1, prob_a=0, prob_b=0 -> every sn=1, result=8 (full window, no wrap).
REQ-038 Mode=0, prob_b=0 -> result=0; mode=1 same operands -> result equals count of bit_a=0 cycles, checked against a reference model.
REQ-039 start pulsed during RUN -> ignored; exactly one result_valid per accepted start; busy high for 9 cycles.
REQ-040 rst_n low at RUN cycle 4 -> all outputs 0, no strobe; a fresh start completes normally.
REQ-041 ena low for 5 cycles mid-RUN -> result unchanged versus the uninterrupted run, and latency extended by 5 cycles.
REQ-042 With SC_LFSR_RESEED_EN, two back-to-back starts with the same operands -> identical result; without it, the LFSR sequence continues, matching the model.
